// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Holds the FSM state encoding, the port/width constants and a helper that
// tells whether an address falls inside the 256-word memory window.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int NUM_PORTS = 2;
  localparam int MEM_AW    = 8;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;

  // Only the low MEM_AW address bits reach the memory; anything above must be zero.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr[ADDR_W-1:MEM_AW] == '0);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
// Port 0 (pipeline MEM stage): req0, we0, addr0, wdata0 -> done0, err0, rdata0, stall0.
// Port 1 (loader/debug):       req1, we1, addr1, wdata1 -> done1, err1, rdata1.
// Memory side: mem_addr, mem_wdata, mem_read, mem_write -> mem_rdata.
// Modport slave is the arbiter view; modport master is the requester/memory view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
  ();

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;
  logic              err0;
  logic [DATA_W-1:0] rdata0;
  logic              stall0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;
  logic              err1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output done0, err0, rdata0, stall0,
    input  req1, we1, addr1, wdata1,
    output done1, err1, rdata1,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  done0, err0, rdata0, stall0,
    output req1, we1, addr1, wdata1,
    input  done1, err1, rdata1,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Arbitration decision for the two request lines.
// Ports: req   - request vector (bit 0 = port 0, bit 1 = port 1)
//        last  - index of the port granted most recently
//        grant - one-hot grant, all zero when nobody requests
// Macro MEM_ARB_RR_EN: defined -> round-robin on a tie (the port not granted
// last wins); undefined -> fixed priority, port 0 always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output logic [NUM_PORTS-1:0] grant
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant = req;
    if (req[0] && req[1]) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end
`else
  // The pointer has no meaning under fixed priority.
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    grant = '0;
    if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one transaction per IDLE -> ACCESS -> DONE pass.
// Ports: clk   - rising-edge clock
//        rst_n - synchronous active-low reset
//        bus   - mem_arbiter_if.slave (both requester ports and the memory side)
// The winner's we/addr/wdata are latched at grant, so requesters may change or
// drop their inputs afterwards without disturbing the transaction. Addresses
// with nonzero bits above the memory window never reach the memory and
// complete with err pulsing alongside done.
// Macro MEM_ARB_RR_EN: defined -> round-robin with a last-grant pointer;
// undefined -> fixed priority (port 0) and no pointer register.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus
);

  state_t                state;
  logic                  port;
  logic                  lat_we;
  logic                  lat_oor;
  logic [NUM_PORTS-1:0]  req_vec;
  logic [NUM_PORTS-1:0]  grant;
  logic                  last;
  logic                  sel_we;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;

  assign req_vec = {bus.req1, bus.req0};

  mem_arb_pick u_pick (
    .req   (req_vec),
    .last  (last),
    .grant (grant)
  );

`ifdef MEM_ARB_RR_EN
  // Reset value 1 makes port 0 the first tie winner.
  logic last_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (state == IDLE && grant != '0) begin
      last_q <= grant[1];
    end
  end
  assign last = last_q;
`else
  assign last = 1'b1;
`endif

  assign sel_we    = grant[1] ? bus.we1    : bus.we0;
  assign sel_addr  = grant[1] ? bus.addr1  : bus.addr0;
  assign sel_wdata = grant[1] ? bus.wdata1 : bus.wdata0;

  assign bus.stall0 = bus.req0 & ~bus.done0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      port          <= 1'b0;
      lat_we        <= 1'b0;
      lat_oor       <= 1'b0;
      bus.done0     <= 1'b0;
      bus.done1     <= 1'b0;
      bus.err0      <= 1'b0;
      bus.err1      <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != '0) begin
            // Memory strobes are loaded here so they are high for exactly the ACCESS cycle.
            port          <= grant[1];
            lat_we        <= sel_we;
            lat_oor       <= ~in_range(sel_addr);
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.mem_read  <= ~sel_we & in_range(sel_addr);
            bus.mem_write <= sel_we & in_range(sel_addr);
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          if (!lat_we && !lat_oor) begin
            if (port) begin
              bus.rdata1 <= bus.mem_rdata;
            end else begin
              bus.rdata0 <= bus.mem_rdata;
            end
          end
          bus.done0 <= ~port;
          bus.done1 <= port;
          bus.err0  <= ~port & lat_oor;
          bus.err1  <= port & lat_oor;
          state     <= DONE;
        end
        DONE: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.err0  <= 1'b0;
          bus.err1  <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic   clk;
  logic   rst_n;
  longint cyc;
  int     errors;
  int     checks;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory: combinational read, write at the clock edge.
  // Writes are suppressed on an edge where reset is asserted.
  logic [31:0] mem [0:255];
  bit          mem_inited;
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) mem[i] <= i;
      mem_inited <= 1'b1;
    end else if (rst_n && bus.mem_write) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:255];
  int          m_last;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    longint      done_cyc;
    bit          aborted;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t make_exp(input int p, input logic w, input logic [31:0] a,
                                    input logic [31:0] d, input longint dc);
    exp_t e;
    e.port = p; e.we = w; e.addr = a; e.wdata = d; e.rdata = '0;
    e.done_cyc = dc; e.aborted = 1'b0;
    e.err = (a[31:8] != 24'd0);
    if (!e.err) begin
      if (w) ref_mem[a[7:0]] = d;
      else   e.rdata = ref_mem[a[7:0]];
    end
    return e;
  endfunction

  // Monitor: compares every cycle against the head of the scoreboard.
  bit          mon_en;
  exp_t        me;
  bit          acc, dn, exp_d0, exp_d1;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata [0:1];

  always @(negedge clk) begin
    if (mon_en) begin
      acc = 1'b0; dn = 1'b0;
      if (sb.size() > 0) begin
        me  = sb[0];
        acc = (cyc == me.done_cyc - 1);
        dn  = (cyc == me.done_cyc);
      end
      if (acc) begin
        m_addr  = me.addr;
        m_wdata = me.wdata;
        chk("mem_read_access",  {31'd0, bus.mem_read},  {31'd0, !me.we && !me.err});
        chk("mem_write_access", {31'd0, bus.mem_write}, {31'd0, me.we && !me.err});
      end else begin
        chk("mem_read_idle",  {31'd0, bus.mem_read},  32'd0);
        chk("mem_write_idle", {31'd0, bus.mem_write}, 32'd0);
      end
      exp_d0 = dn && !me.aborted && (me.port == 0);
      exp_d1 = dn && !me.aborted && (me.port == 1);
      if (dn) begin
        if (me.aborted) begin
          m_rdata[0] = '0; m_rdata[1] = '0; m_addr = '0; m_wdata = '0;
        end else if (!me.we && !me.err) begin
          m_rdata[me.port] = me.rdata;
        end
      end
      chk("mem_addr",  bus.mem_addr,  m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("done0", {31'd0, bus.done0}, {31'd0, exp_d0});
      chk("done1", {31'd0, bus.done1}, {31'd0, exp_d1});
      chk("err0",  {31'd0, bus.err0},  {31'd0, exp_d0 && me.err});
      chk("err1",  {31'd0, bus.err1},  {31'd0, exp_d1 && me.err});
      chk("rdata0", bus.rdata0, m_rdata[0]);
      chk("rdata1", bus.rdata1, m_rdata[1]);
      chk("stall0", {31'd0, bus.stall0}, {31'd0, bus.req0 && !exp_d0});
      if (dn) void'(sb.pop_front());
    end
  end

  // Both ports request together; each holds its request until it has seen
  // n0 / n1 done pulses. Order follows the arbitration rule of the build.
  task automatic run_burst(input int n0, input int n1,
                           input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    int     r0, r1, k, p, budget;
    longint c;
    @(posedge clk); #2;
    c = cyc; r0 = n0; r1 = n1; k = 0;
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) p = (RR && m_last == 0) ? 1 : 0;
      else                  p = (r0 > 0) ? 0 : 1;
      if (p == 0) begin sb.push_back(make_exp(0, w0, a0, d0, c + 2 + 3 * k)); r0--; end
      else        begin sb.push_back(make_exp(1, w1, a1, d1, c + 2 + 3 * k)); r1--; end
      m_last = p;
      k++;
    end
    bus.req0 = (n0 > 0); bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = (n1 > 0); bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    r0 = n0; r1 = n1; budget = 0;
    while ((r0 > 0 || r1 > 0) && budget < 5 * (n0 + n1) + 10) begin
      @(posedge clk); #2;
      budget++;
      if (bus.done0 && r0 > 0) begin r0--; if (r0 == 0) bus.req0 = 1'b0; end
      if (bus.done1 && r1 > 0) begin r1--; if (r1 == 0) bus.req1 = 1'b0; end
    end
    if (r0 > 0 || r1 > 0) begin
      checks++; errors++;
      $display("FAIL burst_timeout: remaining %0d/%0d required 0/0", r0, r1);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      sb.delete();
    end
  endtask

  // Port 1 drops req (and scrambles its inputs) in the ACCESS cycle.
  task automatic run_drop(input logic w, input logic [31:0] a, input logic [31:0] d);
    longint c;
    @(posedge clk); #2;
    c = cyc;
    sb.push_back(make_exp(1, w, a, d, c + 2));
    m_last = 1;
    bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    @(posedge clk); #2;
    bus.req1 = 1'b0; bus.we1 = ~w; bus.addr1 = ~a; bus.wdata1 = ~d;
    repeat (8) @(posedge clk);
    #2;
  endtask

  // Reset lands at the edge closing the ACCESS cycle of a port-1 write.
  task automatic run_reset_mid();
    exp_t   e;
    longint c;
    @(posedge clk); #2;
    c = cyc;
    e.port = 1; e.we = 1'b1; e.addr = 32'd5; e.wdata = 32'hA5A5_0005;
    e.rdata = '0; e.err = 1'b0; e.done_cyc = c + 2; e.aborted = 1'b1;
    sb.push_back(e);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'd5; bus.wdata1 = e.wdata;
    @(posedge clk); #2;
    rst_n = 1'b0; bus.req1 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1; m_last = 1;
    chk("mem5_kept", mem[5], 32'd5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    for (int i = 0; i < 256; i++) ref_mem[i] = i;
    m_last = 1;
    m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    rst_n = 1'b0;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_done0", {31'd0, bus.done0}, 32'd0);
    chk("rst_done1", {31'd0, bus.done1}, 32'd0);
    chk("rst_err0",  {31'd0, bus.err0},  32'd0);
    chk("rst_err1",  {31'd0, bus.err1},  32'd0);
    chk("rst_rdata0", bus.rdata0, 32'd0);
    chk("rst_rdata1", bus.rdata1, 32'd0);
    chk("rst_mem_read",  {31'd0, bus.mem_read},  32'd0);
    chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_mem_addr",  bus.mem_addr,  32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_burst(1, 0, 1'b0, 32'd3, 32'd0, 1'b0, 32'd0, 32'd0);
    run_burst(0, 1, 1'b0, 32'd0, 32'd0, 1'b1, 32'h10, 32'hDEADBEEF);
    run_burst(0, 1, 1'b0, 32'd0, 32'd0, 1'b0, 32'h10, 32'd0);
    run_burst(RR ? 2 : 4, RR ? 2 : 1, 1'b0, 32'd7, 32'd0, 1'b0, 32'd9, 32'd0);
    run_burst(1, 0, 1'b0, 32'h100, 32'd0, 1'b0, 32'd0, 32'd0);
    run_reset_mid();
    run_burst(1, 0, 1'b0, 32'd5, 32'd0, 1'b0, 32'd0, 32'd0);
    run_burst(1, 1, 1'b1, 32'd20, 32'h1234_5678, 1'b0, 32'd20, 32'd0);
    run_drop(1'b0, 32'h10, 32'd0);
    run_drop(1'b1, 32'd33, 32'hCAFE_F00D);

    for (int it = 0; it < 30; it++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if ($urandom_range(0, 5) == 0) begin
        a = $urandom;
        if (a[31:8] == 24'd0) a[8] = 1'b1;
      end
      case ($urandom_range(0, 2))
        0: run_burst(1, 0, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, b, 32'd0);
        1: run_burst(0, 1, 1'b0, a, 32'd0, 1'($urandom_range(0, 1)), b, $urandom);
        default: run_burst($urandom_range(1, 3), $urandom_range(1, 3),
                           1'($urandom_range(0, 1)), a, $urandom,
                           1'($urandom_range(0, 1)), b, $urandom);
      endcase
    end

    repeat (5) @(posedge clk);
    #2;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
